// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with parking on the last owner and a
// contended-hold limit that forces a hand-off at a transfer boundary.
module bus_arbiter #(
    parameter int MASTER_CH = 4,
    parameter int OWNER_W   = 2,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MASTER_CH-1:0] m_req_,
    input  logic                 m_as_,
    input  logic                 m_rdy_,
    output logic [MASTER_CH-1:0] m_grnt_,
    output logic [OWNER_W-1:0]   owner,
    output logic [7:0]           hold_cnt
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    logic [MASTER_CH-1:0] req;
    logic [MASTER_CH-1:0] others;
    logic                 own_req;
    logic                 contended;
    logic                 boundary;
    logic                 force_ho;
    logic                 found;
    logic                 switch_own;
    logic [OWNER_W-1:0]   cand;
    logic [OWNER_W-1:0]   nxt;
    logic [OWNER_W-1:0]   owner_d;
    logic [7:0]           hold_d;

    assign req       = ~m_req_;
    assign own_req   = req[owner];
    assign others    = req & ~(MASTER_CH'(1) << owner);
    assign contended = own_req && (|others);
    assign boundary  = m_as_ || !m_rdy_;
    assign force_ho  = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM) && boundary;

    // First requester after the owner, wrapping; the owner itself is never
    // a candidate, so a release with no other request simply parks.
    always_comb begin
        found = 1'b0;
        nxt   = owner;
        cand  = owner;
        for (int i = 1; i < MASTER_CH; i++) begin
            cand = OWNER_W'((int'(owner) + i) % MASTER_CH);
            if (!found && req[cand]) begin
                found = 1'b1;
                nxt   = cand;
            end
        end
    end

    assign switch_own = found && (!own_req || force_ho);

    always_comb begin
        owner_d = owner;
        hold_d  = 8'd0;
        if (switch_own) begin
            owner_d = nxt;
        end else if (contended) begin
            hold_d = (hold_cnt == 8'hff) ? hold_cnt : hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= '0;
            m_grnt_  <= ~(MASTER_CH'(1));
            hold_cnt <= 8'd0;
        end else begin
            owner    <= owner_d;
            m_grnt_  <= ~(MASTER_CH'(1) << owner_d);
            hold_cnt <= hold_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: three instances share stimulus and
// differ only in MAX_HOLD (16, 4, 0).
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] m_req_;
    logic       m_as_;
    logic       m_rdy_;

    logic [3:0] g16, g4, g0;
    logic [1:0] o16, o4, o0;
    logic [7:0] h16, h4, h0;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter #(.MASTER_CH(4), .OWNER_W(2), .MAX_HOLD(16)) d16 (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_as_(m_as_),
        .m_rdy_(m_rdy_), .m_grnt_(g16), .owner(o16), .hold_cnt(h16)
    );
    bus_arbiter #(.MASTER_CH(4), .OWNER_W(2), .MAX_HOLD(4)) d4 (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_as_(m_as_),
        .m_rdy_(m_rdy_), .m_grnt_(g4), .owner(o4), .hold_cnt(h4)
    );
    bus_arbiter #(.MASTER_CH(4), .OWNER_W(2), .MAX_HOLD(0)) d0 (
        .clk(clk), .reset(reset), .m_req_(m_req_), .m_as_(m_as_),
        .m_rdy_(m_rdy_), .m_grnt_(g0), .owner(o0), .hold_cnt(h0)
    );

    // Grant must be one-hot-low and agree with owner on every cycle.
    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ($countones(~g16) != 1 || g16[o16] !== 1'b0) begin
                failures++;
                $display("FAIL onehot16 grnt=%b owner=%0d", g16, o16);
            end
            checks++;
            if ($countones(~g4) != 1 || g4[o4] !== 1'b0) begin
                failures++;
                $display("FAIL onehot4 grnt=%b owner=%0d", g4, o4);
            end
            checks++;
            if ($countones(~g0) != 1 || g0[o0] !== 1'b0) begin
                failures++;
                $display("FAIL onehot0 grnt=%b owner=%0d", g0, o0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        m_req_ = 4'b1111;
        m_as_  = 1'b1;
        m_rdy_ = 1'b1;
        do_reset();
        armed = 1'b1;
        checks++;
        if (g16 !== 4'b1110 || o16 !== 2'd0 || h16 !== 8'd0) begin
            failures++;
            $display("FAIL reset grnt=%b owner=%0d hold=%0d want 1110/0/0",
                     g16, o16, h16);
        end
        step(5);
        checks++;
        if (g16 !== 4'b1110 || o16 !== 2'd0 || h16 !== 8'd0) begin
            failures++;
            $display("FAIL park0 grnt=%b owner=%0d hold=%0d want 1110/0/0",
                     g16, o16, h16);
        end
    endtask

    task automatic test_release();
        m_req_ = 4'b1011;
        step(1);
        checks++;
        if (o16 !== 2'd2 || g16 !== 4'b1011 || h16 !== 8'd0) begin
            failures++;
            $display("FAIL release grnt=%b owner=%0d hold=%0d want 1011/2/0",
                     g16, o16, h16);
        end
        m_req_ = 4'b0111;
        step(1);
        checks++;
        if (o16 !== 2'd3 || g16 !== 4'b0111) begin
            failures++;
            $display("FAIL to_m3 grnt=%b owner=%0d want 0111/3", g16, o16);
        end
    endtask

    task automatic test_wrap();
        m_req_ = 4'b1101;
        step(1);
        checks++;
        if (o16 !== 2'd1 || g16 !== 4'b1101) begin
            failures++;
            $display("FAIL wrap grnt=%b owner=%0d want 1101/1", g16, o16);
        end
    endtask

    task automatic test_back_to_back();
        m_req_ = 4'b0011;
        step(1);
        checks++;
        if (o16 !== 2'd2 || g16 !== 4'b1011) begin
            failures++;
            $display("FAIL rr_from_old grnt=%b owner=%0d want 1011/2",
                     g16, o16);
        end
        m_req_ = 4'b1110;
        step(1);
        checks++;
        if (o16 !== 2'd0 || g16 !== 4'b1110) begin
            failures++;
            $display("FAIL rereq grnt=%b owner=%0d want 1110/0", g16, o16);
        end
        m_req_ = 4'b1011;
        step(1);
        m_req_ = 4'b1111;
        step(4);
        checks++;
        if (o16 !== 2'd2 || g16 !== 4'b1011 || h16 !== 8'd0) begin
            failures++;
            $display("FAIL park2 grnt=%b owner=%0d hold=%0d want 1011/2/0",
                     g16, o16, h16);
        end
    endtask

    task automatic test_forced_handoff();
        m_req_ = 4'b1100;
        m_as_  = 1'b0;
        m_rdy_ = 1'b1;
        do_reset();
        step(10);
        checks++;
        if (o4 !== 2'd0 || h4 !== 8'd10) begin
            failures++;
            $display("FAIL midxfer owner=%0d hold=%0d want 0/10", o4, h4);
        end
        m_rdy_ = 1'b0;
        step(1);
        checks++;
        if (o4 !== 2'd1 || g4 !== 4'b1101 || h4 !== 8'd0) begin
            failures++;
            $display("FAIL rdy_ho grnt=%b owner=%0d hold=%0d want 1101/1/0",
                     g4, o4, h4);
        end
        checks++;
        if (o16 !== 2'd0 || h16 !== 8'd11) begin
            failures++;
            $display("FAIL below_lim owner=%0d hold=%0d want 0/11", o16, h16);
        end
        m_rdy_ = 1'b1;
        m_as_  = 1'b1;
        do_reset();
        step(4);
        checks++;
        if (o4 !== 2'd0 || h4 !== 8'd4) begin
            failures++;
            $display("FAIL idle_pre owner=%0d hold=%0d want 0/4", o4, h4);
        end
        step(1);
        checks++;
        if (o4 !== 2'd1 || g4 !== 4'b1101 || h4 !== 8'd0) begin
            failures++;
            $display("FAIL idle_ho grnt=%b owner=%0d hold=%0d want 1101/1/0",
                     g4, o4, h4);
        end
    endtask

    task automatic test_no_limit();
        m_req_ = 4'b0110;
        m_as_  = 1'b0;
        m_rdy_ = 1'b1;
        do_reset();
        step(255);
        checks++;
        if (o0 !== 2'd0 || h0 !== 8'd255) begin
            failures++;
            $display("FAIL sat owner=%0d hold=%0d want 0/255", o0, h0);
        end
        m_as_ = 1'b1;
        step(45);
        checks++;
        if (o0 !== 2'd0 || g0 !== 4'b1110 || h0 !== 8'd255) begin
            failures++;
            $display("FAIL nolimit grnt=%b owner=%0d hold=%0d want 1110/0/255",
                     g0, o0, h0);
        end
    endtask

    task automatic test_reset_mid_transfer();
        m_req_ = 4'b1011;
        m_as_  = 1'b1;
        m_rdy_ = 1'b1;
        do_reset();
        step(1);
        m_req_ = 4'b1010;
        m_as_  = 1'b0;
        step(3);
        checks++;
        if (o16 !== 2'd2 || h16 !== 8'd3) begin
            failures++;
            $display("FAIL pre_rst owner=%0d hold=%0d want 2/3", o16, h16);
        end
        do_reset();
        checks++;
        if (o16 !== 2'd0 || g16 !== 4'b1110 || h16 !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid grnt=%b owner=%0d hold=%0d want 1110/0/0",
                     g16, o16, h16);
        end
    endtask

    initial begin
        reset  = 1'b1;
        m_req_ = 4'b1111;
        m_as_  = 1'b1;
        m_rdy_ = 1'b1;
        test_reset();
        test_release();
        test_wrap();
        test_back_to_back();
        test_forced_handoff();
        test_no_limit();
        test_reset_mid_transfer();
        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
